// File: rtl/load_align_unit_pkg.sv
// Shared types and constants for the data-memory load path.
//   BITS / BYTES_PER_WORD : default word geometry
//   mem_data_t            : load type encoding seen on req_type
//   la_state_t            : load_align_unit FSM states
//   access_size()         : bytes touched by a load of a given type
package load_align_unit_pkg;

  localparam int BITS           = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    BYTE      = 3'd0,
    HALFWORD  = 3'd1,
    WORD      = 3'd2,
    UBYTE     = 3'd3,
    UHALFWORD = 3'd4,
    LWCP      = 3'd5
  } mem_data_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } la_state_t;

  // Unused encodings fall through to a full-word access.
  function automatic int access_size(mem_data_t t);
    case (t)
      BYTE, UBYTE:         return 1;
      HALFWORD, UHALFWORD: return 2;
      default:             return BYTES_PER_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// load_extend: combinational sign/zero extension of a realigned load.
//   raw       in  BITS        bytes already shifted down to bit 0
//   data_type in  mem_data_t  load type
//   ext       out BITS        extended result
module load_extend #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0]                 raw,
  input  load_align_unit_pkg::mem_data_t  data_type,
  output logic [BITS-1:0]                 ext
);
  import load_align_unit_pkg::*;

  always_comb begin
    ext = raw;
    case (data_type)
      BYTE:      ext = {{(BITS-8){raw[7]}}, raw[7:0]};
      UBYTE:     ext = {{(BITS-8){1'b0}}, raw[7:0]};
      HALFWORD:  ext = {{(BITS-16){raw[15]}}, raw[15:0]};
      UHALFWORD: ext = {{(BITS-16){1'b0}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: multi-cycle load path to a synchronous word-array memory.
// Handles misaligned loads by reading one or two consecutive words, realigning
// the bytes and extending the result.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_addr byte address, req_type load type
//   mem_rd_en/mem_addr   word read strobe and word address
//   mem_rdata            read data, valid the cycle after mem_rd_en
//   rsp_valid/rsp_ready  response handshake; rsp_data result, rsp_split two reads used
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A request is accepted only in IDLE; once rsp_valid rises, rsp_data and
// rsp_split stay stable until the edge where rsp_ready is sampled high.
module load_align_unit #(
  parameter int BITS           = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 12
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [ADDR_W-1:0]                      req_addr,
  input  load_align_unit_pkg::mem_data_t         req_type,
  output logic                                   mem_rd_en,
  output logic [ADDR_W-$clog2(BYTES_PER_WORD)-1:0] mem_addr,
  input  logic [BITS-1:0]                        mem_rdata,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [BITS-1:0]                        rsp_data,
  output logic                                   rsp_split
);
  import load_align_unit_pkg::*;

  localparam int OFS_W = $clog2(BYTES_PER_WORD);
  localparam int WA_W  = ADDR_W - OFS_W;

  la_state_t         state;
  logic [WA_W-1:0]   w_q;
  logic [OFS_W-1:0]  ofs_q;
  mem_data_t         type_q;
  logic              split_q;
  logic [BITS-1:0]   lo_q;

  logic              req_split;
  logic [2*BITS-1:0] pair;
  logic [2*BITS-1:0] shifted;
  logic [BITS-1:0]   raw;
  logic [BITS-1:0]   ext;

  assign req_ready = (state == IDLE);

  // In CAP the last-read word is on mem_rdata: it is the high word of a
  // split access, or the only word otherwise.
  always_comb begin
    req_split = (int'(req_addr[OFS_W-1:0]) + access_size(req_type)) > BYTES_PER_WORD;
    if (split_q) pair = {mem_rdata, lo_q};
    else         pair = {{BITS{1'b0}}, mem_rdata};
    shifted = pair >> {ofs_q, 3'b000};
    raw     = shifted[BITS-1:0];
  end

  load_extend #(.BITS(BITS)) u_extend (
    .raw       (raw),
    .data_type (type_q),
    .ext       (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      ofs_q     <= '0;
      type_q    <= BYTE;
      split_q   <= 1'b0;
      lo_q      <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_split <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            w_q       <= req_addr[ADDR_W-1:OFS_W];
            ofs_q     <= req_addr[OFS_W-1:0];
            type_q    <= req_type;
            split_q   <= req_split;
            mem_rd_en <= 1'b1;
            mem_addr  <= req_addr[ADDR_W-1:OFS_W];
            state     <= RD0;
          end
        end
        RD0: begin
          if (split_q) begin
            // Word address wraps at the top of the array.
            mem_addr <= w_q + 1'b1;
            state    <= RD1;
          end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            state     <= CAP;
          end
        end
        RD1: begin
          lo_q      <= mem_rdata;
          mem_rd_en <= 1'b0;
          mem_addr  <= '0;
          state     <= CAP;
        end
        CAP: begin
          rsp_data  <= ext;
          rsp_split <= split_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_rd_en <= 1'b0;
          mem_addr  <= '0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
